// File: rtl/lc3b_mem_unit.sv
// lc3b_mem_unit: LC-3b load/store unit with byte-lane steering, sign extension and LDI/STI indirection.
// Optional feature: define LC3B_MEMU_TIMEOUT_EN to build a mem_resp watchdog of TIMEOUT_CYCLES cycles.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_op/req_addr/req_wdata request side;
// rsp_valid/rsp_rdata/rsp_err completion side; mem_read/mem_write/mem_address/mem_wdata/
// mem_byte_enable/mem_resp/mem_rdata unified memory port.
module lc3b_mem_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, PTR, ACC, RSP} state_t;
    state_t      state, state_n;
    logic [2:0]  op, op_n;
    logic [15:0] addr, wdata;
    logic        is_byte, is_wr, wr_n, tmo;
    logic [7:0]  lane;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("lc3b_mem_unit: TIMEOUT_CYCLES must be 1..255");
    end

    // Strobes for the next state are computed from the incoming op while idle, else the latched op.
    assign op_n    = state == IDLE ? req_op : op;
    assign is_byte = op == 3'd1 || op == 3'd3;
    assign is_wr   = op == 3'd2 || op == 3'd3 || op == 3'd5;
    assign wr_n    = op_n == 3'd2 || op_n == 3'd3 || op_n == 3'd5;
    assign lane    = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    assign req_ready       = state == IDLE;
    assign rsp_valid       = state == RSP;
    assign mem_wdata       = wdata;
    assign mem_address     = (state != PTR && is_byte) ? addr : {addr[15:1], 1'b0};
    assign mem_byte_enable = !mem_write ? 2'b11 : !is_byte ? 2'b11 : addr[0] ? 2'b10 : 2'b01;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !req_valid ? IDLE : (req_op == 3'd4 || req_op == 3'd5) ? PTR : ACC;
            PTR:     state_n = tmo ? RSP : mem_resp ? ACC : PTR;
            ACC:     state_n = (mem_resp || tmo) ? RSP : ACC;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= '0;
            addr      <= '0;
            wdata     <= '0;
            rsp_rdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state     <= state_n;
            mem_read  <= state_n == PTR || (state_n == ACC && !wr_n);
            mem_write <= state_n == ACC && wr_n;
            if (state == IDLE && req_valid) begin
                op    <= req_op;
                addr  <= req_addr;
                // Byte stores are replicated on both lanes once at accept time.
                wdata <= req_op == 3'd3 ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
            end
            if (state == PTR && mem_resp)
                addr <= {mem_rdata[15:1], 1'b0};
            if (state == ACC && mem_resp && !is_wr)
                rsp_rdata <= is_byte ? {{8{lane[7]}}, lane} : mem_rdata;
        end
    end

`ifdef LC3B_MEMU_TIMEOUT_EN
    logic [7:0] cnt;

    assign tmo = (state == PTR || state == ACC) && !mem_resp && cnt == 8'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            // Staying in PTR/ACC means no mem_resp this cycle; any transition restarts the count.
            cnt <= (state_n == state && (state == PTR || state == ACC)) ? cnt + 8'd1 : '0;
            if (state == IDLE && req_valid)
                rsp_err <= 1'b0;
            else if (tmo)
                rsp_err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_lc3b_mem_unit.sv
// tb_lc3b_mem_unit: randomized transaction-level check of lc3b_mem_unit against a behavioural model.
module tb_lc3b_mem_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic        chk_en;
    logic        e_ready, e_read, e_write, e_rsp, e_err;
    logic [15:0] e_addr, e_rdata, e_wdata;
    logic [1:0]  e_be;
    logic [15:0] cur_rdata, cur_wdata;
    logic        cur_err;

    lc3b_mem_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", 16'(req_ready), 16'(e_ready));
            cmp("rsp_valid", 16'(rsp_valid), 16'(e_rsp));
            cmp("rsp_err", 16'(rsp_err), 16'(e_err));
            cmp("rsp_rdata", rsp_rdata, e_rdata);
            cmp("mem_read", 16'(mem_read), 16'(e_read));
            cmp("mem_write", 16'(mem_write), 16'(e_write));
            cmp("mem_wdata", mem_wdata, e_wdata);
            cmp("mem_byte_enable", 16'(mem_byte_enable), 16'(e_be));
            if (e_read || e_write)
                cmp("mem_address", mem_address, e_addr);
        end
    end

    task automatic junk_resp();
        mem_resp  = $urandom_range(0, 3) == 0;
        mem_rdata = 16'($urandom);
    endtask

    task automatic idle_cyc();
        e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rsp = 1'b0; e_be = 2'b11;
        e_rdata = cur_rdata; e_wdata = cur_wdata; e_err = cur_err;
        req_valid = 1'b0;
        junk_resp();
        @(posedge clk); #1;
        mem_resp = 1'b0;
    endtask

    // One memory phase of lat cycles with the response in the last one; busy-time requests are noise.
    task automatic phase(input bit wr, input logic [15:0] ad, input logic [1:0] be,
                         input int lat, input logic [15:0] d);
        for (int i = 1; i <= lat; i++) begin
            e_ready = 1'b0; e_rsp = 1'b0; e_read = !wr; e_write = wr;
            e_addr = ad; e_be = wr ? be : 2'b11;
            mem_resp  = i == lat;
            mem_rdata = i == lat ? d : 16'($urandom);
            req_valid = $urandom_range(0, 1) == 1;
            req_op    = 3'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            @(posedge clk); #1;
        end
        mem_resp  = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w,
                           input logic [15:0] d1, input logic [15:0] d2, input int l1, input int l2);
        logic [15:0] p, ad, data, wd;
        logic [7:0]  b;
        logic [1:0]  be;
        bit          ind, byt, rd;
        ind = op == 3'd4 || op == 3'd5;
        byt = op == 3'd1 || op == 3'd3;
        rd  = !(op == 3'd2 || op == 3'd3 || op == 3'd5);
        wd  = op == 3'd3 ? {w[7:0], w[7:0]} : w;
        e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rsp = 1'b0; e_be = 2'b11;
        e_rdata = cur_rdata; e_wdata = cur_wdata; e_err = cur_err;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
        junk_resp();
        @(posedge clk); #1;
        req_valid = 1'b0;
        cur_wdata = wd; cur_err = 1'b0; e_wdata = wd; e_err = 1'b0;
        p = a;
        if (ind) begin
            phase(1'b0, {a[15:1], 1'b0}, 2'b11, l1, d1);
            p = {d1[15:1], 1'b0};
        end
        ad   = byt ? p : {p[15:1], 1'b0};
        be   = !byt ? 2'b11 : p[0] ? 2'b10 : 2'b01;
        data = ind ? d2 : d1;
        phase(!rd, ad, be, ind ? l2 : l1, data);
        if (rd) begin
            b = ad[0] ? data[15:8] : data[7:0];
            cur_rdata = byt ? {{8{b[7]}}, b} : data;
        end
        e_ready = 1'b0; e_read = 1'b0; e_write = 1'b0; e_rsp = 1'b1; e_be = 2'b11; e_rdata = cur_rdata;
        junk_resp();
        req_valid = $urandom_range(0, 1) == 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_resp  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0; chk_en = 1'b0;
        cur_rdata = '0; cur_wdata = '0; cur_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_req_ready", 16'(req_ready), 16'd1);
        cmp("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        cmp("rst_rsp_err", 16'(rsp_err), 16'd0);
        cmp("rst_rsp_rdata", rsp_rdata, 16'h0000);
        cmp("rst_mem_read", 16'(mem_read), 16'd0);
        cmp("rst_mem_write", 16'(mem_write), 16'd0);
        cmp("rst_mem_address", mem_address, 16'h0000);
        cmp("rst_mem_byte_enable", 16'(mem_byte_enable), 16'd3);
        cmp("rst_mem_wdata", mem_wdata, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        run_req(3'd0, 16'h3001, 16'h0000, 16'hBEEF, 16'h0, 2, 1);
        cmp("lit_rd_word", rsp_rdata, 16'hBEEF);
        run_req(3'd1, 16'h1003, 16'h0000, 16'h80AA, 16'h0, 1, 1);
        cmp("lit_rd_byte_odd", rsp_rdata, 16'hFF80);
        run_req(3'd1, 16'h1002, 16'h0000, 16'h80AA, 16'h0, 3, 1);
        cmp("lit_rd_byte_even", rsp_rdata, 16'hFFAA);
        run_req(3'd3, 16'h2005, 16'h1234, 16'h0000, 16'h0, 2, 1);
        cmp("lit_wr_byte_wdata", mem_wdata, 16'h3434);
        cmp("lit_wr_keeps_rdata", rsp_rdata, 16'hFFAA);
        run_req(3'd4, 16'h4000, 16'h0000, 16'h5003, 16'h00C1, 2, 3);
        cmp("lit_rd_ind", rsp_rdata, 16'h00C1);
        run_req(3'd7, 16'h0011, 16'h0000, 16'h7E01, 16'h0, 1, 1);
        cmp("lit_op7_word", rsp_rdata, 16'h7E01);

        // Reset in the middle of a read access.
        e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rsp = 1'b0; e_be = 2'b11;
        e_rdata = cur_rdata; e_wdata = cur_wdata; e_err = cur_err;
        req_valid = 1'b1; req_op = 3'd0; req_addr = 16'h0ABC; req_wdata = 16'h1111;
        @(posedge clk); #1;
        req_valid = 1'b0; e_ready = 1'b0; e_read = 1'b1; e_addr = 16'h0ABC; e_wdata = 16'h1111;
        @(negedge clk); #2;
        chk_en = 1'b0;
        reset = 1'b1;
        #1;
        cmp("rstmid_mem_read", 16'(mem_read), 16'd0);
        cmp("rstmid_req_ready", 16'(req_ready), 16'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_resp = i == 0; mem_rdata = 16'hDEAD;
            @(negedge clk);
            cmp("rstmid_no_rsp", 16'(rsp_valid), 16'd0);
            cmp("rstmid_idle", 16'(req_ready), 16'd1);
            cmp("rstmid_no_strobe", 16'({mem_read, mem_write}), 16'd0);
            cmp("rstmid_rdata", rsp_rdata, 16'h0000);
            @(posedge clk); #1;
        end
        mem_resp = 1'b0;
        cur_rdata = '0; cur_wdata = '0; cur_err = 1'b0;
        chk_en = 1'b1;

        for (int n = 0; n < 200; n++) begin
            run_req(3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0)
                idle_cyc();
        end

`ifdef LC3B_MEMU_TIMEOUT_EN
        e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rsp = 1'b0; e_be = 2'b11;
        e_rdata = cur_rdata; e_wdata = cur_wdata; e_err = cur_err;
        req_valid = 1'b1; req_op = 3'd2; req_addr = 16'h1235; req_wdata = 16'h5678;
        @(posedge clk); #1;
        req_valid = 1'b0; cur_wdata = 16'h5678; e_wdata = 16'h5678; e_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e_ready = 1'b0; e_write = 1'b1; e_addr = 16'h1234; e_be = 2'b11;
            @(posedge clk); #1;
        end
        e_write = 1'b0; e_be = 2'b11; e_rsp = 1'b1; e_err = 1'b1; cur_err = 1'b1;
        @(negedge clk);
        cmp("lit_tmo_err", 16'(rsp_err), 16'd1);
        @(posedge clk); #1;
        run_req(3'd0, 16'h0100, 16'h0, 16'h2468, 16'h0, 1, 1);
        cmp("lit_tmo_err_cleared", 16'(rsp_err), 16'd0);
`endif

        idle_cyc();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
